ept_block_receiver: RTL and testbench

- Sits directly downstream of the active transfer library's user-side block-transfer byte stream. Consumes bytes addressed to one endpoint.
- Packs the bytes little-endian into 32-bit words, marks transfer boundaries, and buffers the words in a first-word-fall-through FIFO.
- Presents the words to user logic on a valid/ready interface and reports overflow when the FIFO fills.

---
 rtl/ept_block_receiver.sv | 158 +++++++++++++++
 tb/tb_ept_block_receiver.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ept_block_receiver.sv
// ept_block_receiver: packs endpoint-addressed block-transfer bytes little-endian into
// 32-bit words and buffers them in a first-word-fall-through FIFO. Optional: EPT_RX_DROP_COUNT_EN.
module ept_block_receiver #(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned LEVEL_W       = 5,
  parameter logic [2:0]  ENDPOINT_ADDR = 3'd2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               block_xfer_strobe_i,
  input  logic [7:0]         block_xfer_byte_i,
  input  logic [2:0]         block_xfer_addr_i,
  input  logic               block_xfer_end_i,
  output logic [31:0]        word_data_o,
  output logic [3:0]         word_keep_o,
  output logic               word_last_o,
  output logic               word_valid_o,
  input  logic               word_ready_i,
  output logic [LEVEL_W-1:0] fifo_level_o,
  output logic               overflow_o,
  input  logic               clr_overflow_i
`ifdef EPT_RX_DROP_COUNT_EN
  ,
  output logic [15:0]        drop_count_o
`endif
);

  localparam int unsigned AW = LEVEL_W - 1;
  localparam logic [LEVEL_W-1:0] LEVEL_ONE = LEVEL_W'(1);

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  // Packer state
  logic [1:0]  idx_q, idx_d;
  logic [31:0] lane_q, lane_d;
  word_t       pend_q, pend_d;
  logic        pend_valid_q, pend_valid_d;

  // FIFO state
  word_t              mem [DEPTH];
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  word_t              last_pop_q, last_pop_d;
  logic               overflow_q, overflow_d;

  logic        accept, end_hit, emit;
  logic [31:0] merged;
  logic [2:0]  fill;
  logic        full, pop, wr_en, drop;
  word_t       head, out_w;

  assign head  = mem[rd_ptr_q[AW-1:0]];
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = word_valid_o && word_ready_i;
  assign wr_en = pend_valid_q && (!full || pop);
  assign drop  = pend_valid_q && full && !pop;

  // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    accept  = block_xfer_strobe_i && (block_xfer_addr_i == ENDPOINT_ADDR);
    end_hit = block_xfer_end_i && (block_xfer_addr_i == ENDPOINT_ADDR);
    merged  = lane_q;
    if (accept) merged[{idx_q, 3'b000} +: 8] = block_xfer_byte_i;

    // Lanes above the fill count are already zero because the lane register clears on emit.
    fill         = {1'b0, idx_q} + {2'b00, accept};
    emit         = (accept && (idx_q == 2'd3)) || end_hit;
    pend_d.data  = merged;
    pend_d.keep  = 4'((5'd1 << fill) - 5'd1);
    pend_d.last  = end_hit;
    pend_valid_d = emit;

    idx_d  = idx_q;
    lane_d = lane_q;
    if (emit) begin
      idx_d  = '0;
      lane_d = '0;
    end else if (accept) begin
      idx_d  = idx_q + 2'd1;
      lane_d = merged;
    end

    wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    last_pop_d = pop ? head : last_pop_q;
    unique case ({wr_en, pop})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase

    // A drop in the same cycle as a clear wins.
    overflow_d = overflow_q;
    if (drop) overflow_d = 1'b1;
    else if (clr_overflow_i) overflow_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      lane_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      last_pop_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      lane_q       <= lane_d;
      if (emit) pend_q <= pend_d;
      pend_valid_q <= pend_valid_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      last_pop_q   <= last_pop_d;
      overflow_q   <= overflow_d;
    end
  end

  // NOTE: the storage array is not reset; the output mux never exposes it while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= pend_q;
  end

  assign word_valid_o = (level_q != '0);
  assign out_w        = word_valid_o ? head : last_pop_q;
  assign word_data_o  = out_w.data;
  assign word_keep_o  = out_w.keep;
  assign word_last_o  = out_w.last;
  assign fifo_level_o = level_q;
  assign overflow_o   = overflow_q;

`ifdef EPT_RX_DROP_COUNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clr_overflow_i) drop_cnt_d = drop ? 16'd1 : 16'd0;
    else if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_ept_block_receiver.sv
// tb_ept_block_receiver: table-driven, directed multi-cycle and randomized scoreboard
// checks of ept_block_receiver (default DEPTH=16, endpoint 2).
module tb_ept_block_receiver;

  localparam logic [2:0] EP = 3'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        strobe = 1'b0, end_p = 1'b0, ready = 1'b0, clr = 1'b0;
  logic [7:0]  byt = '0;
  logic [2:0]  addr = '0;
  logic [31:0] data;
  logic [3:0]  keep;
  logic        last, valid, ov;
  logic [4:0]  level;
`ifdef EPT_RX_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } w_t;

  typedef struct {
    logic        s;
    logic [2:0]  a;
    logic [7:0]  b;
    logic        e;
    logic        ev;
    logic [31:0] ed;
    logic [3:0]  ek;
    logic        el;
    logic [4:0]  elev;
  } vec_t;

  vec_t       vq[$];
  logic [7:0] cur[$];
  w_t         exp_q[$];

  always #5 clk = ~clk;

  ept_block_receiver dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .block_xfer_strobe_i (strobe),
    .block_xfer_byte_i   (byt),
    .block_xfer_addr_i   (addr),
    .block_xfer_end_i    (end_p),
    .word_data_o         (data),
    .word_keep_o         (keep),
    .word_last_o         (last),
    .word_valid_o        (valid),
    .word_ready_i        (ready),
    .fifo_level_o        (level),
    .overflow_o          (ov),
    .clr_overflow_i      (clr)
`ifdef EPT_RX_DROP_COUNT_EN
    ,
    .drop_count_o        (drop_count)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic s, input logic [2:0] a, input logic [7:0] b,
                        input logic e, input logic r, input logic c);
    strobe = s; addr = a; byt = b; end_p = e; ready = r; clr = c;
  endtask

  task automatic drive(input logic s, input logic [2:0] a, input logic [7:0] b,
                       input logic e, input logic r, input logic c);
    set_in(s, a, b, e, r, c);
    tick;
  endtask

  function automatic void row(input logic s, input logic [2:0] a, input logic [7:0] b,
                              input logic e, input logic ev, input logic [31:0] ed,
                              input logic [3:0] ek, input logic el, input logic [4:0] elev);
    vec_t v;
    v.s = s; v.a = a; v.b = b; v.e = e;
    v.ev = ev; v.ed = ed; v.ek = ek; v.el = el; v.elev = elev;
    vq.push_back(v);
  endfunction

  // Word i carries bytes i*4 .. i*4+3, first byte in the low lane.
  function automatic logic [31:0] mk(input int i);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(i * 4 + k);
    return w;
  endfunction

  task automatic push_word(input int i, input logic rdy_on_push, input logic clr_on_push);
    for (int k = 0; k < 4; k++) drive(1'b1, EP, 8'(i * 4 + k), 1'b0, 1'b0, 1'b0);
    drive(1'b0, EP, 8'h00, 1'b0, rdy_on_push, clr_on_push);
    set_in(1'b0, EP, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int first, input int n, input string tag);
    for (int j = 0; j < n; j++) begin
      set_in(1'b0, EP, 8'h00, 1'b0, 1'b1, 1'b0);
      check($sformatf("%s valid %0d", tag, j), 64'(valid), 64'(1));
      check($sformatf("%s word %0d", tag, j), 64'({data, keep, last}), 64'({mk(first + j), 4'hF, 1'b0}));
      tick;
    end
    set_in(1'b0, EP, 8'h00, 1'b0, 1'b0, 1'b0);
    check($sformatf("%s empty", tag), 64'({valid, level}), 64'(0));
  endtask

  // Reference packer: bytes of the current word are collected in a queue and a word is
  // released when four bytes are held or the endpoint's END arrives.
  function automatic void model_step(input logic s, input logic [2:0] a, input logic [7:0] b, input logic e);
    w_t w;
    logic hit_e;
    hit_e = e && (a == EP);
    if (s && (a == EP)) cur.push_back(b);
    if ((cur.size() == 4) || hit_e) begin
      w = '0;
      foreach (cur[k]) w.d[8*k +: 8] = cur[k];
      w.k = 4'((1 << cur.size()) - 1);
      w.l = hit_e;
      exp_q.push_back(w);
      cur.delete();
    end
  endfunction

  task automatic score(input string tag);
    w_t w;
    if (valid && ready) begin
      if (exp_q.size() == 0) begin
        check({tag, " unexpected word"}, 64'({data, keep, last}), 64'(0));
      end else begin
        w = exp_q.pop_front();
        check({tag, " word"}, 64'({data, keep, last}), 64'(w));
      end
    end
  endtask

  initial begin
    logic s, e, r;
    logic [2:0] a;
    logic [7:0] b;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("reset data", 64'(data), 64'(0));
    check("reset keep/last/valid", 64'({keep, last, valid}), 64'(0));
    check("reset level", 64'(level), 64'(0));
    check("reset overflow", 64'(ov), 64'(0));
`ifdef EPT_RX_DROP_COUNT_EN
    check("reset drop_count", 64'(drop_count), 64'(0));
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Table: READY held high, outputs checked before each edge.
    row(1, EP, 8'h11, 0, 0, 0, 0, 0, 0);
    row(1, EP, 8'h22, 0, 0, 0, 0, 0, 0);
    row(1, EP, 8'h33, 0, 0, 0, 0, 0, 0);
    row(1, EP, 8'h44, 1, 0, 0, 0, 0, 0);
    row(0, EP, 8'h00, 0, 0, 0, 0, 0, 0);
    row(0, EP, 8'h00, 0, 1, 32'h44332211, 4'hF, 1, 1);
    row(0, EP, 8'h00, 0, 0, 0, 0, 0, 0);
    row(1, EP, 8'h01, 0, 0, 0, 0, 0, 0);
    row(1, EP, 8'h02, 0, 0, 0, 0, 0, 0);
    row(1, EP, 8'h03, 0, 0, 0, 0, 0, 0);
    row(1, EP, 8'h04, 0, 0, 0, 0, 0, 0);
    row(1, EP, 8'h05, 0, 0, 0, 0, 0, 0);
    row(1, EP, 8'h06, 0, 1, 32'h04030201, 4'hF, 0, 1);
    row(0, EP, 8'h00, 1, 0, 0, 0, 0, 0);
    row(0, EP, 8'h00, 0, 0, 0, 0, 0, 0);
    row(0, EP, 8'h00, 0, 1, 32'h00000605, 4'h3, 1, 1);
    row(0, EP, 8'h00, 0, 0, 0, 0, 0, 0);
    row(1, EP, 8'hAA, 0, 0, 0, 0, 0, 0);
    row(1, 3'd5, 8'h55, 0, 0, 0, 0, 0, 0);
    row(1, EP, 8'hBB, 0, 0, 0, 0, 0, 0);
    row(1, 3'd5, 8'h77, 1, 0, 0, 0, 0, 0);
    row(1, EP, 8'hCC, 0, 0, 0, 0, 0, 0);
    row(1, 3'd5, 8'h66, 0, 0, 0, 0, 0, 0);
    row(1, EP, 8'hDD, 0, 0, 0, 0, 0, 0);
    row(0, EP, 8'h00, 0, 0, 0, 0, 0, 0);
    row(0, EP, 8'h00, 1, 1, 32'hDDCCBBAA, 4'hF, 0, 1);
    row(0, EP, 8'h00, 0, 0, 0, 0, 0, 0);
    row(0, EP, 8'h00, 0, 1, 32'h00000000, 4'h0, 1, 1);
    row(0, EP, 8'h00, 0, 0, 0, 0, 0, 0);
    row(1, EP, 8'hEE, 1, 0, 0, 0, 0, 0);
    row(0, EP, 8'h00, 0, 0, 0, 0, 0, 0);
    row(0, EP, 8'h00, 0, 1, 32'h000000EE, 4'h1, 1, 1);
    row(0, EP, 8'h00, 0, 0, 0, 0, 0, 0);

    foreach (vq[i]) begin
      set_in(vq[i].s, vq[i].a, vq[i].b, vq[i].e, 1'b1, 1'b0);
      check($sformatf("tbl%0d valid", i), 64'(valid), 64'(vq[i].ev));
      check($sformatf("tbl%0d level", i), 64'(level), 64'(vq[i].elev));
      if (vq[i].ev) begin
        check($sformatf("tbl%0d data", i), 64'(data), 64'(vq[i].ed));
        check($sformatf("tbl%0d keep/last", i), 64'({keep, last}), 64'({vq[i].ek, vq[i].el}));
      end
      tick;
    end
    set_in(1'b0, EP, 8'h00, 1'b0, 1'b0, 1'b0);

    // Overflow: fill, drop two, then a drop coinciding with a clear.
    for (int i = 0; i < 16; i++) push_word(i, 1'b0, 1'b0);
    check("ovf full level", 64'(level), 64'(16));
    check("ovf not yet", 64'(ov), 64'(0));
    push_word(16, 1'b0, 1'b0);
    check("ovf first drop", 64'({ov, level}), 64'({1'b1, 5'd16}));
    push_word(17, 1'b0, 1'b0);
    check("ovf second drop", 64'({ov, level}), 64'({1'b1, 5'd16}));
`ifdef EPT_RX_DROP_COUNT_EN
    check("ovf drop_count", 64'(drop_count), 64'(2));
`endif
    push_word(18, 1'b0, 1'b1);
    check("ovf set beats clear", 64'(ov), 64'(1));
`ifdef EPT_RX_DROP_COUNT_EN
    check("ovf drop_count clear+drop", 64'(drop_count), 64'(1));
`endif
    drive(1'b0, EP, 8'h00, 1'b0, 1'b0, 1'b1);
    clr = 1'b0;
    check("ovf cleared", 64'(ov), 64'(0));
`ifdef EPT_RX_DROP_COUNT_EN
    check("ovf drop_count cleared", 64'(drop_count), 64'(0));
`endif
    drain(0, 16, "ovf drain");

    // Full FIFO with a pop on the push edge.
    for (int i = 0; i < 16; i++) push_word(20 + i, 1'b0, 1'b0);
    check("full level", 64'(level), 64'(16));
    push_word(36, 1'b1, 1'b0);
    check("full+pop level", 64'(level), 64'(16));
    check("full+pop overflow", 64'(ov), 64'(0));
    check("full+pop head", 64'(data), 64'(mk(21)));
    drain(21, 16, "full drain");

    // Reset mid-word with a word waiting in the FIFO.
    push_word(40, 1'b0, 1'b0);
    drive(1'b1, EP, 8'hA1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, EP, 8'hA2, 1'b0, 1'b0, 1'b0);
    set_in(1'b0, EP, 8'h00, 1'b0, 1'b0, 1'b0);
    check("pre-reset valid", 64'(valid), 64'(1));
    #3 rst_n = 1'b0;
    #1;
    check("mid reset outputs", 64'({data, keep, last, valid, level, ov}), 64'(0));
    tick;
    check("held reset outputs", 64'({data, keep, last, valid, level, ov}), 64'(0));
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) drive(1'b1, EP, 8'(k), 1'(k == 4), 1'b1, 1'b0);
    set_in(1'b0, EP, 8'h00, 1'b0, 1'b1, 1'b0);
    check("post-reset pending", 64'(valid), 64'(0));
    tick;
    check("post-reset word", 64'({data, keep, last, level}), 64'({32'h04030201, 4'hF, 1'b1, 5'd1}));
    tick;
    check("post-reset empty", 64'({valid, level}), 64'(0));

    // Randomized traffic against the reference packer.
    for (int n = 0; n < 800; n++) begin
      s = ($urandom_range(0, 9) < 4);
      a = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : EP;
      b = 8'($urandom);
      e = ($urandom_range(0, 11) == 0);
      r = ($urandom_range(0, 3) != 0);
      set_in(s, a, b, e, r, 1'b0);
      model_step(s, a, b, e);
      score("rnd");
      tick;
    end
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) begin
      set_in(1'b0, EP, 8'h00, 1'b0, 1'b1, 1'b0);
      score("rnd drain");
      tick;
    end
    check("rnd words outstanding", 64'(exp_q.size()), 64'(0));
    check("rnd final empty", 64'({valid, level}), 64'(0));
    check("rnd overflow", 64'(ov), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
